addsub_seq_ctrl: RTL



---
 rtl/addsub_seq_ctrl_pkg.sv | 20 ++
 rtl/addsub_seq_ctrl_if.sv | 36 +++
 rtl/addsub_seq_ctrl_slice.sv | 31 +++
 rtl/addsub_seq_ctrl.sv | 123 ++++++++++++
 4 files changed

// File: rtl/addsub_seq_ctrl_pkg.sv
// Shared definitions for the sliced add/subtract sequencer.
// Holds the controller state type, the default slice geometry and a
// helper that derives the full operand width from that geometry.
package addsub_seq_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam int DEF_SLICE_W    = 8;
  localparam int DEF_NUM_SLICES = 4;

  // Full operand width in bits.
  function automatic int calc_n(input int slice_w, input int num_slices);
    return slice_w * num_slices;
  endfunction

endpackage

// File: rtl/addsub_seq_ctrl_if.sv
// Request/response bundle of the sliced add/subtract sequencer.
//
// Handshake: a request is taken on a rising clk edge where start=1,
// ready=1 and flush=0; a, b and sb are captured on that same edge.
// There is no response backpressure: done is a one-cycle valid pulse
// qualifying s, c_out and of. flush aborts the operation in flight.
//
// Signals:
//   start, sb, a, b, flush : requester -> sequencer
//   ready, busy, done      : sequencer status
//   s, c_out, of           : result, carry out of MSB, signed overflow
interface addsub_seq_ctrl_if #(
  parameter int N = 32
) ();
  logic         start;
  logic         sb;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic         flush;
  logic         ready;
  logic         busy;
  logic         done;
  logic [N-1:0] s;
  logic         c_out;
  logic         of;

  modport master (
    output start, sb, a, b, flush,
    input  ready, busy, done, s, c_out, of
  );

  modport slave (
    input  start, sb, a, b, flush,
    output ready, busy, done, s, c_out, of
  );
endinterface

// File: rtl/addsub_seq_ctrl_slice.sv
// addsub_slice: combinational SLICE_W-bit adder slice.
// Ports:
//   x, y     : slice operands
//   cin      : carry into bit 0
//   sum      : slice sum
//   cout     : carry out of the slice MSB
//   c_msb_in : carry into the slice MSB (signed overflow = c_msb_in ^ cout)
module addsub_slice #(
  parameter int SLICE_W = 8
) (
  input  logic [SLICE_W-1:0] x,
  input  logic [SLICE_W-1:0] y,
  input  logic               cin,
  output logic [SLICE_W-1:0] sum,
  output logic               cout,
  output logic               c_msb_in
);

  logic [SLICE_W-1:0] low_sum;
  logic [1:0]         msb_sum;

  // The MSB is added separately so the carry into it is visible.
  assign low_sum = {1'b0, x[SLICE_W-2:0]} + {1'b0, y[SLICE_W-2:0]}
                 + {{(SLICE_W-1){1'b0}}, cin};
  assign c_msb_in = low_sum[SLICE_W-1];
  assign msb_sum  = {1'b0, x[SLICE_W-1]} + {1'b0, y[SLICE_W-1]}
                  + {1'b0, c_msb_in};
  assign sum  = {msb_sum[0], low_sum[SLICE_W-2:0]};
  assign cout = msb_sum[1];

endmodule

// File: rtl/addsub_seq_ctrl.sv
// addsub_seq_ctrl: multi-cycle wide add/subtract using one narrow slice.
// A request is latched in IDLE or DONE, then one SLICE_W slice is
// computed per cycle in RUN (LSB slice first), chaining the carry. The
// final slice also registers c_out and the signed overflow flag. DONE
// pulses done for one cycle and can accept the next request directly.
// Ports:
//   clk, rst_n : clock, synchronous active-low reset
//   bus        : request/response interface (slave side)
//   dbg_state  : current controller state
module addsub_seq_ctrl
  import addsub_seq_ctrl_pkg::*;
#(
  parameter int SLICE_W    = DEF_SLICE_W,
  parameter int NUM_SLICES = DEF_NUM_SLICES
) (
  input  logic                clk,
  input  logic                rst_n,
  addsub_seq_ctrl_if.slave    bus,
  output state_t              dbg_state
);

  localparam int N     = calc_n(SLICE_W, NUM_SLICES);
  localparam int IDX_W = $clog2(NUM_SLICES);

  state_t             state;
  state_t             state_nxt;
  logic [IDX_W-1:0]   idx;
  logic               carry;
  logic [N-1:0]       a_q;
  logic [N-1:0]       b_q;      // already inverted for subtract
  logic [N-1:0]       s_q;
  logic               c_out_q;
  logic               of_q;

  logic               accept;
  logic               last;
  int                 base;
  logic [SLICE_W-1:0] x;
  logic [SLICE_W-1:0] y;
  logic [SLICE_W-1:0] sum;
  logic               cout;
  logic               c_msb_in;

  // flush beats start in every state.
  assign accept = bus.start && bus.ready && !bus.flush;
  assign last   = (idx == IDX_W'(NUM_SLICES - 1));
  assign base   = int'(idx) * SLICE_W;

  always_comb begin
    x = a_q[base +: SLICE_W];
    y = b_q[base +: SLICE_W];
  end

  addsub_slice #(.SLICE_W(SLICE_W)) u_slice (
    .x        (x),
    .y        (y),
    .cin      (carry),
    .sum      (sum),
    .cout     (cout),
    .c_msb_in (c_msb_in)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: state_nxt = accept ? ST_RUN : ST_IDLE;
      ST_RUN: begin
        if (bus.flush) state_nxt = ST_IDLE;
        else if (last) state_nxt = ST_DONE;
        else           state_nxt = ST_RUN;
      end
      ST_DONE: state_nxt = accept ? ST_RUN : ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Outputs.
  always_comb begin
    bus.ready = (state != ST_RUN);
    bus.busy  = (state == ST_RUN);
    bus.done  = (state == ST_DONE) && !bus.flush;
  end

  assign bus.s     = s_q;
  assign bus.c_out = c_out_q;
  assign bus.of    = of_q;
  assign dbg_state = state;

  // Datapath. A flushed RUN simply stops updating; the partial result
  // stays put and is never signalled valid.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      idx     <= '0;
      carry   <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      s_q     <= '0;
      c_out_q <= 1'b0;
      of_q    <= 1'b0;
    end else if (accept) begin
      a_q   <= bus.a;
      b_q   <= bus.sb ? ~bus.b : bus.b;
      carry <= bus.sb;
      idx   <= '0;
    end else if (state == ST_RUN && !bus.flush) begin
      s_q[base +: SLICE_W] <= sum;
      carry                <= cout;
      idx                  <= last ? '0 : idx + IDX_W'(1);
      if (last) begin
        c_out_q <= cout;
        of_q    <= c_msb_in ^ cout;
      end
    end
  end

endmodule
